pe_scan: RTL and testbench

PE_SCAN -- requirements
Module: pe_scan

---
 rtl/pe_pkg.sv | 19 +
 rtl/pe_enc.sv | 53 +++++
 rtl/pe_scan.sv | 97 +++++++++
 tb/tb_pe_scan.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared types and defaults for the pe_scan priority scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage : pe_pkg

`default_nettype wire

// File: rtl/pe_enc.sv
// ============================================================================
//  Module      : pe_enc
//  Description : Combinational priority encoder: index, zero flag and one-hot
//                mask of the selected bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_enc #(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1,
  parameter int W         = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         zero,
  output logic [N-1:0] onehot
);

  assign zero = (vec == '0);

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      // Ascending scan: the last hit overwrites, leaving the highest set bit.
      always_comb begin
        idx    = '0;
        onehot = '0;
        for (int i = 0; i < N; i++) begin
          if (vec[i]) begin
            idx       = W'(i);
            onehot    = '0;
            onehot[i] = 1'b1;
          end
        end
      end
    end else begin : g_lsb_first
      always_comb begin
        idx    = '0;
        onehot = '0;
        for (int i = N - 1; i >= 0; i--) begin
          if (vec[i]) begin
            idx       = W'(i);
            onehot    = '0;
            onehot[i] = 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule : pe_enc

`default_nettype wire

// File: rtl/pe_scan.sv
// ============================================================================
//  Module      : pe_scan
//  Description : Captures a request vector and emits one beat per set bit in
//                priority order, with valid/ready flow control on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_scan
  import pe_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter int W         = $clog2(N),
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] idx,
  output logic         none,
  output logic         last
);

  state_e       state_q, state_d;
  logic [N-1:0] rem_q, rem_d;

  logic [W-1:0] w_enc_idx;
  logic         w_enc_zero;
  logic [N-1:0] w_enc_onehot;
  logic         w_at_most_one;
  logic         w_fire;
  logic         w_accept;

  pe_enc #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST),
    .W         (W)
  ) u_enc (
    .vec    (rem_q),
    .idx    (w_enc_idx),
    .zero   (w_enc_zero),
    .onehot (w_enc_onehot)
  );

  // Clearing the lowest set bit leaves zero iff at most one bit was set.
  assign w_at_most_one = ((rem_q & (rem_q - {{(N-1){1'b0}}, 1'b1})) == '0);

  always_comb begin
    out_valid = 1'b0;
    idx       = '0;
    none      = 1'b0;
    last      = 1'b0;
    if (state_q == SCAN) begin
      out_valid = 1'b1;
      idx       = w_enc_idx;
      none      = w_enc_zero;
      last      = w_at_most_one;
    end
  end

  assign w_fire   = out_valid & out_ready;
  assign in_ready = (state_q == IDLE) | (w_fire & last);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (w_accept) begin
      state_d = SCAN;
      rem_d   = req;
    end else if (w_fire) begin
      if (last) begin
        state_d = IDLE;
        rem_d   = '0;
      end else begin
        rem_d = rem_q & ~w_enc_onehot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

endmodule : pe_scan

`default_nettype wire

// File: tb/tb_pe_scan.sv
// ============================================================================
//  Module      : tb_pe_scan
//  Description : Scoreboard bench driving an MSB-first and an LSB-first pe_scan
//                with identical directed stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] req;

  logic       in_ready_m, out_valid_m, none_m, last_m;
  logic [2:0] idx_m;
  logic       in_ready_l, out_valid_l, none_l, last_l;
  logic [2:0] idx_l;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0] q_m[$];
  logic [4:0] q_l[$];

  always #5 clk = ~clk;

  pe_scan #(.N(8), .MSB_FIRST(1)) u_dut_m (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_m),
    .req       (req),
    .out_valid (out_valid_m),
    .out_ready (out_ready),
    .idx       (idx_m),
    .none      (none_m),
    .last      (last_m)
  );

  pe_scan #(.N(8), .MSB_FIRST(0)) u_dut_l (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_l),
    .req       (req),
    .out_valid (out_valid_l),
    .out_ready (out_ready),
    .idx       (idx_l),
    .none      (none_l),
    .last      (last_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat encoding: {idx[2:0], none, last}
  function automatic logic [4:0] bt(input int i, input logic n, input logic l);
    return {3'(i), n, l};
  endfunction

  // Monitors: compare every accepted beat against the head of its queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid_m === 1'b1 && out_ready === 1'b1) begin
      if (q_m.size() == 0) chk("msb_unexpected_beat", {idx_m, none_m, last_m}, 5'h1f ^ {idx_m, none_m, last_m});
      else                 chk("msb_beat", {idx_m, none_m, last_m}, q_m.pop_front());
    end
    if (rst_n === 1'b1 && out_valid_l === 1'b1 && out_ready === 1'b1) begin
      if (q_l.size() == 0) chk("lsb_unexpected_beat", {idx_l, none_l, last_l}, 5'h1f ^ {idx_l, none_l, last_l});
      else                 chk("lsb_beat", {idx_l, none_l, last_l}, q_l.pop_front());
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    req       = 8'h00;
    #1;
    chk("rst_in_ready",  in_ready_m,  1);
    chk("rst_out_valid", out_valid_m, 0);
    chk("rst_outs",      {idx_m, none_m, last_m}, 0);
    chk("rst_lsb",       {in_ready_l, out_valid_l, idx_l, none_l, last_l}, 7'b1000000);
    #12 rst_n = 1'b1;
    tick();

    // 8'b1010_0100: MSB beats 7,5,2 ; LSB beats 2,5,7
    q_m.push_back(bt(7,0,0)); q_m.push_back(bt(5,0,0)); q_m.push_back(bt(2,0,1));
    q_l.push_back(bt(2,0,0)); q_l.push_back(bt(5,0,0)); q_l.push_back(bt(7,0,1));
    in_valid = 1'b1; req = 8'hA4;
    tick();
    in_valid = 1'b0;
    chk("a4_latency_valid", out_valid_m, 1);
    chk("a4_busy_in_ready", in_ready_m, 0);
    tick(); tick();
    chk("a4_third_in_ready", in_ready_m, 1);
    chk("a4_third_last", last_m, 1);
    tick();
    chk("a4_idle", out_valid_m, 0);

    // All-zero vector: one beat idx=0 none=1 last=1
    q_m.push_back(bt(0,1,1));
    q_l.push_back(bt(0,1,1));
    in_valid = 1'b1; req = 8'h00;
    tick();
    in_valid = 1'b0;
    chk("zero_in_ready", in_ready_m, 1);
    tick();
    chk("zero_idle", out_valid_m, 0);
    chk("zero_idle_outs", {idx_m, none_m, last_m}, 0);

    // 8'h81 with a 3-cycle stall
    q_m.push_back(bt(7,0,0)); q_m.push_back(bt(0,0,1));
    q_l.push_back(bt(0,0,0)); q_l.push_back(bt(7,0,1));
    out_ready = 1'b0;
    in_valid = 1'b1; req = 8'h81;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_idx_msb",  {out_valid_m, idx_m, last_m}, {1'b1, 3'd7, 1'b0});
      chk("stall_in_ready", in_ready_m, 0);
      chk("stall_idx_lsb",  idx_l, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("stall_second", {idx_m, last_m}, {3'd0, 1'b1});
    tick();
    chk("stall_idle", out_valid_m, 0);

    // Back-to-back: 8'h01 then 8'h10 offered during the last beat
    q_m.push_back(bt(0,0,1)); q_m.push_back(bt(4,0,1));
    q_l.push_back(bt(0,0,1)); q_l.push_back(bt(4,0,1));
    in_valid = 1'b1; req = 8'h01;
    tick();
    req = 8'h10;
    chk("b2b_in_ready", in_ready_m, 1);
    tick();
    in_valid = 1'b0;
    chk("b2b_no_bubble", {out_valid_m, idx_m}, {1'b1, 3'd4});
    tick();
    chk("b2b_idle", out_valid_m, 0);

    // 8'hFF with reset pulsed after the second accepted beat
    q_m.push_back(bt(7,0,0)); q_m.push_back(bt(6,0,0));
    q_l.push_back(bt(0,0,0)); q_l.push_back(bt(1,0,0));
    in_valid = 1'b1; req = 8'hFF;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("ff_pre_reset_idx", idx_m, 5);
    rst_n = 1'b0;
    #1;
    chk("ff_reset_out_valid", {out_valid_m, out_valid_l}, 0);
    chk("ff_reset_in_ready",  in_ready_m, 1);
    #1 rst_n = 1'b1;
    tick(); tick(); tick();
    chk("ff_after_out_valid", {out_valid_m, out_valid_l}, 0);
    chk("ff_after_in_ready",  {in_ready_m, in_ready_l}, 2'b11);

    chk("q_msb_drained", q_m.size(), 0);
    chk("q_lsb_drained", q_l.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pe_scan

`default_nettype wire
